// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: default operand width, counter
// width and the number of FSM cycles spent on each quotient bit.
package div_pkg;
    localparam int N_DEF          = 8;
    localparam int CW_DEF         = $clog2(N_DEF);
    localparam int CYCLES_PER_BIT = 2;
endpackage

// File: rtl/div_counter.sv
// Iteration counter: synchronous clear beats increment; zc flags the last bit.
module div_counter #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sclr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          zc
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (sclr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign zc = (count == CW'(N - 1));
endmodule

// File: rtl/divider_datapath.sv
// Datapath of the iterative restoring divider. It executes the FSM strobes and
// returns cout (R >= B) and zC (last iteration) back to the FSM.
module divider_datapath
    import div_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] A_in,
    input  logic [N-1:0] B_in,
    input  logic         LAB,
    input  logic         EA,
    input  logic         ER,
    input  logic         LR,
    input  logic         sclrR,
    input  logic         EC,
    input  logic         sclrC,
    input  logic         done,
    output logic         cout,
    output logic         zC,
    output logic [N-1:0] Q,
    output logic [N-1:0] Rem,
    output logic         valid,
    output logic         dbz
);
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N:0]    r_q;
    logic [N:0]    diff;
    logic [CW-1:0] c_q;

    // R carries one guard bit so the shifted remainder never overflows
    // before it is compared against the divisor.
    assign diff = r_q - {1'b0, b_q};
    assign cout = (r_q >= {1'b0, b_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (LAB) begin
            a_q <= A_in;
            b_q <= B_in;
        end else if (EA) begin
            a_q <= {a_q[N-2:0], cout};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (sclrR) begin
            r_q <= '0;
        end else if (ER && LR) begin
            r_q <= diff;
        end else if (ER) begin
            r_q <= {r_q[N-1:0], a_q[N-1]};
        end
    end

    div_counter #(.N(N), .CW(CW)) u_counter (
        .clk   (clk),
        .reset (reset),
        .sclr  (sclrC),
        .en    (EC),
        .count (c_q),
        .zc    (zC)
    );

    // Result handshake: valid is high exactly on the cycles after done was
    // sampled high; Q/Rem/dbz are stable and meaningful only while valid=1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q     <= '0;
            Rem   <= '0;
            dbz   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= done;
            if (done) begin
                Q   <= a_q;
                Rem <= r_q[N-1:0];
                dbz <= (b_q == '0);
            end
        end
    end
endmodule
